// File: rtl/uart_rx_deserializer.sv
// UART receive deserialiser: synchronises the rx pin, finds the start bit on a
// 16x sample tick, samples data/parity/stop at mid-bit and writes good bytes to the RX FIFO.
module uart_rx_deserializer #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p_SampleTick_i,
   input  logic                  SerialData_i,
   input  logic                  p_BigEnd_i,
   input  logic                  p_ParityEn_i,
   input  logic                  p_ParityOdd_i,
   input  logic                  p_FifoFull_i,
   output logic                  n_FifoWe_o,
   output logic [DATA_WIDTH-1:0] FifoData_o,
   output logic                  p_ParityErr_o,
   output logic                  p_FrameErr_o,
   output logic                  p_Overrun_o,
   output logic [4:0]            State_o
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [4:0] {
      IDLE      = 5'b00001,
      STARTBIT  = 5'b00010,
      DATABITS  = 5'b00100,
      PARITYBIT = 5'b01000,
      STOPBIT   = 5'b10000
   } state_t;

   state_t                r_State;
   logic [1:0]            r_Sync;
   logic [CW-1:0]         r_Cnt;
   logic [BW-1:0]         r_BitCnt;
   logic [DATA_WIDTH-1:0] r_Shift;
   logic                  r_BigEnd;
   logic                  r_ParEn;
   logic                  r_ParOdd;
   logic                  r_ParMis;
   logic                  r_BreakWait;

   logic                  w_RxS;
   logic [BW-1:0]         w_Idx;
   logic                  w_ParExp;

   assign w_RxS    = r_Sync[1];
   assign w_Idx    = r_BigEnd ? (BIT_LAST - r_BitCnt) : r_BitCnt;
   assign w_ParExp = (^r_Shift) ^ r_ParOdd;
   assign State_o  = r_State;

   // Idle-high synchroniser so reset never looks like a start bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_Sync <= 2'b11;
      end else begin
         r_Sync <= {r_Sync[0], SerialData_i};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_State       <= IDLE;
         r_Cnt         <= '0;
         r_BitCnt      <= '0;
         r_Shift       <= '0;
         r_BigEnd      <= 1'b0;
         r_ParEn       <= 1'b0;
         r_ParOdd      <= 1'b0;
         r_ParMis      <= 1'b0;
         r_BreakWait   <= 1'b0;
         n_FifoWe_o    <= 1'b1;
         FifoData_o    <= '0;
         p_ParityErr_o <= 1'b0;
         p_FrameErr_o  <= 1'b0;
         p_Overrun_o   <= 1'b0;
      end else begin
         n_FifoWe_o    <= 1'b1;
         p_ParityErr_o <= 1'b0;
         p_FrameErr_o  <= 1'b0;
         p_Overrun_o   <= 1'b0;
         if (p_SampleTick_i) begin
            case (r_State)
               IDLE: begin
                  // After a framing error, wait for the line to return high before re-arming
                  if (r_BreakWait) begin
                     if (w_RxS) r_BreakWait <= 1'b0;
                  end else if (!w_RxS) begin
                     r_State <= STARTBIT;
                     r_Cnt   <= '0;
                  end
               end
               STARTBIT: begin
                  if (r_Cnt == CNT_MID) begin
                     r_Cnt <= '0;
                     if (!w_RxS) begin
                        r_State  <= DATABITS;
                        r_BitCnt <= '0;
                        r_Shift  <= '0;
                        r_ParMis <= 1'b0;
                        r_BigEnd <= p_BigEnd_i;
                        r_ParEn  <= p_ParityEn_i;
                        r_ParOdd <= p_ParityOdd_i;
                     end else begin
                        r_State <= IDLE;
                     end
                  end else begin
                     r_Cnt <= r_Cnt + 1'b1;
                  end
               end
               DATABITS: begin
                  if (r_Cnt == CNT_LAST) begin
                     r_Cnt          <= '0;
                     r_Shift[w_Idx] <= w_RxS;
                     r_BitCnt       <= r_BitCnt + 1'b1;
                     if (r_BitCnt == BIT_LAST) begin
                        r_State <= r_ParEn ? PARITYBIT : STOPBIT;
                     end
                  end else begin
                     r_Cnt <= r_Cnt + 1'b1;
                  end
               end
               PARITYBIT: begin
                  if (r_Cnt == CNT_LAST) begin
                     r_Cnt    <= '0;
                     r_ParMis <= (w_RxS != w_ParExp);
                     r_State  <= STOPBIT;
                  end else begin
                     r_Cnt <= r_Cnt + 1'b1;
                  end
               end
               STOPBIT: begin
                  // Back to IDLE on the stop sample itself so the next start edge is not missed
                  if (r_Cnt == CNT_LAST) begin
                     r_Cnt   <= '0;
                     r_State <= IDLE;
                     if (!w_RxS) begin
                        p_FrameErr_o <= 1'b1;
                        r_BreakWait  <= 1'b1;
                     end else if (p_FifoFull_i) begin
                        p_Overrun_o   <= 1'b1;
                        p_ParityErr_o <= r_ParMis;
                     end else begin
                        n_FifoWe_o    <= 1'b0;
                        FifoData_o    <= r_Shift;
                        p_ParityErr_o <= r_ParMis;
                     end
                  end else begin
                     r_Cnt <= r_Cnt + 1'b1;
                  end
               end
               default: r_State <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: drives serial frames on a 4-clk sample tick
// and checks FIFO writes, error pulses and state against hand-computed values.
module tb_uart_rx_deserializer;

   localparam int BITCLK = 64;
   localparam logic [4:0] S_IDLE     = 5'b00001;
   localparam logic [4:0] S_STARTBIT = 5'b00010;
   localparam logic [4:0] S_DATABITS = 5'b00100;

   logic       clk;
   logic       rst;
   logic       p_SampleTick_i;
   logic       SerialData_i;
   logic       p_BigEnd_i;
   logic       p_ParityEn_i;
   logic       p_ParityOdd_i;
   logic       p_FifoFull_i;
   logic       n_FifoWe_o;
   logic [7:0] FifoData_o;
   logic       p_ParityErr_o;
   logic       p_FrameErr_o;
   logic       p_Overrun_o;
   logic [4:0] State_o;

   int testsRun = 0;
   int failCount = 0;
   int cycle = 0;
   int writeCount = 0;
   int parErrCount = 0;
   int frameErrCount = 0;
   int overrunCount = 0;
   logic [7:0] lastData = '0;
   logic       lastWriteParErr = 1'b0;
   int         writeTimes[$];
   logic [7:0] writeData[$];

   uart_rx_deserializer #(.OVERSAMPLE(16), .DATA_WIDTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .p_SampleTick_i (p_SampleTick_i),
      .SerialData_i   (SerialData_i),
      .p_BigEnd_i     (p_BigEnd_i),
      .p_ParityEn_i   (p_ParityEn_i),
      .p_ParityOdd_i  (p_ParityOdd_i),
      .p_FifoFull_i   (p_FifoFull_i),
      .n_FifoWe_o     (n_FifoWe_o),
      .FifoData_o     (FifoData_o),
      .p_ParityErr_o  (p_ParityErr_o),
      .p_FrameErr_o   (p_FrameErr_o),
      .p_Overrun_o    (p_Overrun_o),
      .State_o        (State_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One sample tick every 4 clocks, so a bit time is 64 clocks
   initial begin
      int phase;
      phase = 0;
      p_SampleTick_i = 1'b0;
      forever begin
         @(negedge clk);
         phase = (phase + 1) % 4;
         p_SampleTick_i = (phase == 0);
      end
   end

   // Counts every active clock of each output strobe, so a stretched pulse shows up as extra counts
   initial begin
      forever begin
         @(negedge clk);
         cycle++;
         if (n_FifoWe_o === 1'b0) begin
            writeCount++;
            lastData = FifoData_o;
            lastWriteParErr = p_ParityErr_o;
            writeTimes.push_back(cycle);
            writeData.push_back(FifoData_o);
         end
         if (p_ParityErr_o === 1'b1) parErrCount++;
         if (p_FrameErr_o === 1'b1) frameErrCount++;
         if (p_Overrun_o === 1'b1) overrunCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clearMon();
      writeCount = 0;
      parErrCount = 0;
      frameErrCount = 0;
      overrunCount = 0;
      lastData = '0;
      lastWriteParErr = 1'b0;
      writeTimes.delete();
      writeData.delete();
   endtask

   task automatic sendBit(input logic b);
      SerialData_i = b;
      repeat (BITCLK) @(negedge clk);
   endtask

   task automatic idleBits(input int n);
      SerialData_i = 1'b1;
      repeat (n * BITCLK) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic msbFirst,
                                input logic hasPar, input logic parBit, input logic stopBit);
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(msbFirst ? data[7-i] : data[i]);
      if (hasPar) sendBit(parBit);
      sendBit(stopBit);
   endtask

   initial begin
      int spacing;
      logic [7:0] firstData;
      rst = 1'b0;
      SerialData_i = 1'b1;
      p_BigEnd_i = 1'b0;
      p_ParityEn_i = 1'b0;
      p_ParityOdd_i = 1'b0;
      p_FifoFull_i = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_state", State_o, S_IDLE);
      checkOutput("reset_we", n_FifoWe_o, 1);
      checkOutput("reset_data", FifoData_o, 0);
      checkOutput("reset_errs", {p_ParityErr_o, p_FrameErr_o, p_Overrun_o}, 0);
      rst = 1'b1;
      idleBits(2);

      // Little end, no parity, 0xA5
      clearMon();
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      idleBits(1);
      checkOutput("le_write_count", writeCount, 1);
      checkOutput("le_data", lastData, 8'hA5);
      checkOutput("le_errs", parErrCount + frameErrCount + overrunCount, 0);
      checkOutput("le_state", State_o, S_IDLE);

      // Big end, even parity, parity bit 0 matches 0x3C
      clearMon();
      p_BigEnd_i = 1'b1;
      p_ParityEn_i = 1'b1;
      p_ParityOdd_i = 1'b0;
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      idleBits(1);
      checkOutput("be_even_write", writeCount, 1);
      checkOutput("be_even_data", lastData, 8'h3C);
      checkOutput("be_even_perr", parErrCount, 0);

      // Same line bits under odd parity: mismatch reported with the write
      clearMon();
      p_ParityOdd_i = 1'b1;
      applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
      idleBits(1);
      checkOutput("be_odd_write", writeCount, 1);
      checkOutput("be_odd_data", lastData, 8'h3C);
      checkOutput("be_odd_perr_at_we", lastWriteParErr, 1);
      checkOutput("be_odd_perr_count", parErrCount, 1);
      p_BigEnd_i = 1'b0;
      p_ParityEn_i = 1'b0;
      p_ParityOdd_i = 1'b0;

      // Glitch: 4 ticks low then high
      clearMon();
      SerialData_i = 1'b0;
      repeat (16) @(negedge clk);
      SerialData_i = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("glitch_startbit", State_o, S_STARTBIT);
      idleBits(2);
      checkOutput("glitch_idle", State_o, S_IDLE);
      checkOutput("glitch_quiet", writeCount + parErrCount + frameErrCount + overrunCount, 0);

      // Framing error on 0x55, line held low, then a clean 0x12
      clearMon();
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      SerialData_i = 1'b0;
      repeat (3 * BITCLK) @(negedge clk);
      checkOutput("break_hold_idle", State_o, S_IDLE);
      checkOutput("frame_err", frameErrCount, 1);
      checkOutput("frame_no_write", writeCount, 0);
      idleBits(2);
      applyStimulus(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
      idleBits(1);
      checkOutput("after_break_write", writeCount, 1);
      checkOutput("after_break_data", lastData, 8'h12);

      // FIFO full during 0x81
      clearMon();
      p_FifoFull_i = 1'b1;
      applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
      idleBits(1);
      p_FifoFull_i = 1'b0;
      checkOutput("overrun_pulse", overrunCount, 1);
      checkOutput("overrun_no_write", writeCount, 0);
      checkOutput("overrun_no_perr", parErrCount, 0);

      // Back-to-back 0x01, 0x02: writes exactly 10 bit times apart
      clearMon();
      applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h02, 1'b0, 1'b0, 1'b0, 1'b1);
      idleBits(1);
      spacing = (writeTimes.size() >= 2) ? (writeTimes[1] - writeTimes[0]) : -1;
      firstData = (writeData.size() >= 1) ? writeData[0] : 8'hxx;
      checkOutput("b2b_count", writeCount, 2);
      checkOutput("b2b_first", firstData, 8'h01);
      checkOutput("b2b_second", lastData, 8'h02);
      checkOutput("b2b_spacing", spacing, 10 * BITCLK);

      // Reset in the middle of bit 4 of 0xF0
      clearMon();
      sendBit(1'b0);
      for (int i = 0; i < 4; i++) sendBit(1'b0);
      SerialData_i = 1'b1;
      repeat (32) @(negedge clk);
      checkOutput("pre_reset_databits", State_o, S_DATABITS);
      rst = 1'b0;
      #1;
      checkOutput("midreset_state", State_o, S_IDLE);
      checkOutput("midreset_we", n_FifoWe_o, 1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      idleBits(2);
      checkOutput("midreset_quiet", writeCount + parErrCount + frameErrCount + overrunCount, 0);
      applyStimulus(8'h3A, 1'b0, 1'b0, 1'b0, 1'b1);
      idleBits(1);
      checkOutput("post_reset_write", writeCount, 1);
      checkOutput("post_reset_data", lastData, 8'h3A);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
